// File: rtl/midi_pkg.sv
// ============================================================================
// midi_pkg : shared MIDI event/status constants, parser states, length helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package midi_pkg;

  localparam logic [1:0] EV_NOTE_OFF = 2'd0;
  localparam logic [1:0] EV_NOTE_ON  = 2'd1;
  localparam logic [1:0] EV_CC       = 2'd2;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROGRAM  = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D1 = 2'd1,
    S_WAIT_D2 = 2'd2
  } parse_state_e;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic [1:0] msg_data_len(input logic [3:0] nibble);
    if (nibble == ST_PROGRAM || nibble == ST_CHAN_AT) return 2'd1;
    return 2'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/midi_rx_controller.sv
// ============================================================================
// midi_rx_controller : pops UART bytes, parses MIDI with running status and
//                      emits note/CC events. Define MIDI_RX_CC_EN for CC events.
// Revision : 1.0
// ============================================================================
`default_nettype none

module midi_rx_controller
  import midi_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_re,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_type,
  output logic [3:0] ev_chan,
  output logic [6:0] ev_d1,
  output logic [6:0] ev_d2
);

  logic         pop_q;
  parse_state_e state_q;
  logic [7:0]   status_q;
  logic [6:0]   d1_q;
  logic         ev_valid_q;
  logic [1:0]   ev_type_q;
  logic [3:0]   ev_chan_q;
  logic [6:0]   ev_d1_q;
  logic [6:0]   ev_d2_q;

  logic         emit_d;
  logic [1:0]   type_d;
  logic         kind_ok;
  logic         chan_ok;

  // The guard flop covers the cycle where the UART still shows the old byte.
  assign rx_re = resetn & rx_valid & (~ev_valid_q | ev_ready) & ~pop_q;

  always_comb begin
    type_d  = EV_NOTE_ON;
    kind_ok = 1'b0;
    chan_ok = OMNI || (status_q[3:0] == CHANNEL);
    case (status_q[7:4])
      ST_NOTE_OFF: begin
        type_d  = EV_NOTE_OFF;
        kind_ok = 1'b1;
      end
      ST_NOTE_ON: begin
        type_d  = (rx_data[6:0] == 7'd0) ? EV_NOTE_OFF : EV_NOTE_ON;
        kind_ok = 1'b1;
      end
      ST_CC: begin
`ifdef MIDI_RX_CC_EN
        type_d  = EV_CC;
        kind_ok = 1'b1;
`endif
      end
      default: ;
    endcase
    emit_d = rx_re && !rx_data[7] && (state_q == S_WAIT_D2) && chan_ok && kind_ok;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pop_q      <= 1'b0;
      state_q    <= S_IDLE;
      status_q   <= 8'h00;
      d1_q       <= 7'd0;
      ev_valid_q <= 1'b0;
      ev_type_q  <= 2'd0;
      ev_chan_q  <= 4'd0;
      ev_d1_q    <= 7'd0;
      ev_d2_q    <= 7'd0;
    end else begin
      pop_q <= rx_re;
      if (ev_valid_q && ev_ready) ev_valid_q <= 1'b0;
      if (emit_d) begin
        ev_valid_q <= 1'b1;
        ev_type_q  <= type_d;
        ev_chan_q  <= status_q[3:0];
        ev_d1_q    <= d1_q;
        ev_d2_q    <= rx_data[6:0];
      end
      // Realtime bytes (F8-FF) fall through untouched.
      if (rx_re && rx_data < 8'hF8) begin
        if (rx_data >= 8'hF0) begin
          state_q  <= S_IDLE;
          status_q <= 8'h00;
        end else if (rx_data[7]) begin
          state_q  <= S_WAIT_D1;
          status_q <= rx_data;
        end else begin
          case (state_q)
            S_WAIT_D1: begin
              d1_q    <= rx_data[6:0];
              state_q <= (msg_data_len(status_q[7:4]) == 2'd2) ? S_WAIT_D2 : S_WAIT_D1;
            end
            S_WAIT_D2: state_q <= S_WAIT_D1;
            default: ;
          endcase
        end
      end
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_type  = ev_type_q;
  assign ev_chan  = ev_chan_q;
  assign ev_d1    = ev_d1_q;
  assign ev_d2    = ev_d2_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_rx_controller.sv
// ============================================================================
// tb_midi_rx_controller : two DUTs (omni, and channel-1 only) fed the same byte
//                         stream; scoreboard against a byte-stream parser model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_midi_rx_controller;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       rxv_a = 1'b0, rxv_b = 1'b0;
  logic [7:0] rxd_a = 8'h00, rxd_b = 8'h00;
  logic       re_a, re_b, evv_a, evv_b;
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  logic [1:0] typ_a, typ_b;
  logic [3:0] ch_a, ch_b;
  logic [6:0] d1_a, d1_b, d2_a, d2_b;

  midi_rx_controller #(.OMNI(1'b1), .CHANNEL(4'd0)) u_a (
    .clk(clk), .resetn(resetn), .rx_valid(rxv_a), .rx_data(rxd_a), .rx_re(re_a),
    .ev_valid(evv_a), .ev_ready(rdy_a), .ev_type(typ_a), .ev_chan(ch_a),
    .ev_d1(d1_a), .ev_d2(d2_a));

  midi_rx_controller #(.OMNI(1'b0), .CHANNEL(4'd1)) u_b (
    .clk(clk), .resetn(resetn), .rx_valid(rxv_b), .rx_data(rxd_b), .rx_re(re_b),
    .ev_valid(evv_b), .ev_ready(rdy_b), .ev_type(typ_b), .ev_chan(ch_b),
    .ev_d1(d1_b), .ev_d2(d2_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART buffer model: rx_valid drops one cycle after the consuming strobe.
  logic [7:0] qa[$], qb[$];
  bit pend_a = 0, pend_b = 0;

  always @(posedge clk) begin
    if (pend_a && qa.size() > 0) void'(qa.pop_front());
    pend_a = re_a;
    rxv_a <= (qa.size() != 0);
    rxd_a <= (qa.size() != 0) ? qa[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (pend_b && qb.size() > 0) void'(qb.pop_front());
    pend_b = re_b;
    rxv_b <= (qb.size() != 0);
    rxd_b <= (qb.size() != 0) ? qb[0] : 8'h00;
  end

  // Reference: stream-level parser, one context per DUT (0 = omni, 1 = channel 1).
  int m_stat[2];
  int m_d1[2];
  bit m_have[2];
  logic [19:0] exp_a[$], exp_b[$];

  function automatic logic [19:0] mk(input int ty, input int ch, input int a, input int b);
    return {2'(ty), 4'(ch), 7'(a), 7'(b)};
  endfunction

  task automatic model_byte(input int d, input logic [7:0] b);
    int kind, need, ty, chan;
    bit emit;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_stat[d] = 0; m_have[d] = 0; return; end
    if (b[7]) begin m_stat[d] = int'(b); m_have[d] = 0; return; end
    if (m_stat[d] == 0) return;
    kind = m_stat[d] / 16;
    chan = m_stat[d] % 16;
    need = (kind == 12 || kind == 13) ? 1 : 2;
    if (need == 2 && !m_have[d]) begin m_d1[d] = int'(b); m_have[d] = 1; return; end
    m_have[d] = 0;
    if (need == 1) return;
    emit = 0;
    ty = 0;
    if (kind == 8) begin emit = 1; ty = 0; end
    else if (kind == 9) begin emit = 1; ty = (b == 8'h00) ? 0 : 1; end
`ifdef MIDI_RX_CC_EN
    else if (kind == 11) begin emit = 1; ty = 2; end
`endif
    if (emit && (d == 0 || chan == 1)) begin
      if (d == 0) exp_a.push_back(mk(ty, chan, m_d1[d], int'(b)));
      else        exp_b.push_back(mk(ty, chan, m_d1[d], int'(b)));
    end
  endtask

  task automatic send(input logic [7:0] b);
    qa.push_back(b);
    qb.push_back(b);
    model_byte(0, b);
    model_byte(1, b);
  endtask

  // Consumer + monitor, evaluated mid-cycle.
  int rdy_mode = 0;
  int nev[2];
  logic [19:0] last_ev[2];
  bit pv[2], pr[2], pre[2];
  logic [19:0] pf[2];

  task automatic mon(input int d, input logic v, input logic [19:0] f, input logic r, input logic re);
    logic [19:0] e;
    if (pv[d] && !pr[d]) begin
      chk("stall_valid_held", 32'(v), 32'd1);
      chk("stall_fields_stable", 32'(f), 32'(pf[d]));
    end
    if (v && !pv[d]) chk("valid_one_cycle_after_pop", 32'(pre[d]), 32'd1);
    if (v && !r) chk("no_pop_while_stalled", 32'(re), 32'd0);
    if (v && r) begin
      nev[d]++;
      last_ev[d] = f;
      if ((d == 0 ? exp_a.size() : exp_b.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event dut%0d: got %0h expected none", d, f);
      end else begin
        e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
        chk(d == 0 ? "event_a" : "event_b", 32'(f), 32'(e));
      end
    end
    pv[d] = v; pr[d] = r; pf[d] = f; pre[d] = re;
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0: begin rdy_a = 1'b1; rdy_b = 1'b1; end
      1: begin rdy_a = 1'($urandom_range(0, 1)); rdy_b = 1'($urandom_range(0, 1)); end
      default: begin rdy_a = 1'b0; rdy_b = 1'b0; end
    endcase
    if (resetn) begin
      mon(0, evv_a, {typ_a, ch_a, d1_a, d2_a}, rdy_a, re_a);
      mon(1, evv_b, {typ_b, ch_b, d1_b, d2_b}, rdy_b, re_b);
    end else begin
      pv = '{0, 0};
      pre = '{0, 0};
    end
  end

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      done = (qa.size() == 0) && (qb.size() == 0) && !pend_a && !pend_b && !evv_a && !evv_b;
    end
    chk("drain_timeout", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid_a();
    bit seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      seen = evv_a;
    end
    chk("wait_valid_timeout", 32'(seen), 32'd1);
  endtask

  typedef struct {
    int          n;
    logic [47:0] bytes;
    int          na;
    int          nb;
    logic [19:0] la;
    logic [19:0] lb;
  } vec_t;

  vec_t tv[10];

  initial begin
    m_stat = '{0, 0};
    m_have = '{0, 0};
    m_d1 = '{0, 0};

    tv[0] = '{3, 48'h903C64_000000, 1, 0, mk(1, 0, 'h3C, 'h64), 20'h0};
    tv[1] = '{5, 48'h92407F41_0000, 2, 0, mk(0, 2, 'h41, 0), 20'h0};
    tv[2] = '{5, 48'h90F83CFE50_00, 1, 0, mk(1, 0, 'h3C, 'h50), 20'h0};
    tv[3] = '{6, 48'h903C64913C64, 2, 1, mk(1, 1, 'h3C, 'h64), mk(1, 1, 'h3C, 'h64)};
    tv[4] = '{5, 48'hC105913C64_00, 1, 1, mk(1, 1, 'h3C, 'h64), mk(1, 1, 'h3C, 'h64)};
`ifdef MIDI_RX_CC_EN
    tv[5] = '{3, 48'hB00764_000000, 1, 0, mk(2, 0, 7, 'h64), 20'h0};
`else
    tv[5] = '{3, 48'hB00764_000000, 0, 0, 20'h0, 20'h0};
`endif
    tv[6] = '{3, 48'hF03C64_000000, 0, 0, 20'h0, 20'h0};
    tv[7] = '{3, 48'h813020_000000, 1, 1, mk(0, 1, 'h30, 'h20), mk(0, 1, 'h30, 'h20)};
    tv[8] = '{6, 48'hE11020915010, 1, 1, mk(1, 1, 'h50, 'h10), mk(1, 1, 'h50, 'h10)};
    tv[9] = '{5, 48'h913CF24050_00, 0, 0, 20'h0, 20'h0};

    resetn = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_rx_re", 32'(re_a), 32'd0);
    chk("rst_ev_valid_a", 32'(evv_a), 32'd0);
    chk("rst_fields_a", 32'({typ_a, ch_a, d1_a, d2_a}), 32'd0);
    chk("rst_ev_valid_b", 32'(evv_b), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send(8'hF7);
      drain();
      nev = '{0, 0};
      last_ev = '{20'h0, 20'h0};
      for (int j = 0; j < tv[i].n; j++) send(tv[i].bytes[47 - 8*j -: 8]);
      drain();
      chk($sformatf("vec%0d_count_a", i), 32'(nev[0]), 32'(tv[i].na));
      chk($sformatf("vec%0d_count_b", i), 32'(nev[1]), 32'(tv[i].nb));
      if (tv[i].na > 0) chk($sformatf("vec%0d_last_a", i), 32'(last_ev[0]), 32'(tv[i].la));
      if (tv[i].nb > 0) chk($sformatf("vec%0d_last_b", i), 32'(last_ev[1]), 32'(tv[i].lb));
    end

    // Backpressure: second message must stay in the UART while the first is held.
    nev = '{0, 0};
    rdy_mode = 2;
    send(8'h90); send(8'h3C); send(8'h64); send(8'h90); send(8'h40); send(8'h50);
    wait_valid_a();
    repeat (30) @(negedge clk);
    chk("bp_first_fields", 32'({typ_a, ch_a, d1_a, d2_a}), 32'(mk(1, 0, 'h3C, 'h64)));
    chk("bp_bytes_held", 32'(qa.size()), 32'd3);
    rdy_mode = 0;
    drain();
    chk("bp_events_a", 32'(nev[0]), 32'd2);

    // Reset with an event pending and a partial message behind it.
    nev = '{0, 0};
    rdy_mode = 2;
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3C);
    wait_valid_a();
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    qa.delete(); qb.delete();
    pend_a = 0; pend_b = 0;
    exp_a.delete(); exp_b.delete();
    m_stat = '{0, 0};
    m_have = '{0, 0};
    repeat (2) @(negedge clk);
    chk("rst_mid_ev_valid", 32'(evv_a), 32'd0);
    chk("rst_mid_rx_re", 32'(re_a), 32'd0);
    resetn = 1'b1;
    rdy_mode = 0;
    send(8'h40); send(8'h50);
    drain();
    chk("rst_mid_no_event", 32'(nev[0] + nev[1]), 32'd0);

    // Random byte stream with random consumer stalls.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       send(8'($urandom_range(8'hF8, 8'hFF)));
      else if (r < 12) send(8'($urandom_range(8'hF0, 8'hF7)));
      else if (r < 35) send(8'({4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))}));
      else             send(8'($urandom_range(0, 127)));
    end
    drain();
    rdy_mode = 0;
    chk("rand_expected_left_a", 32'(exp_a.size()), 32'd0);
    chk("rand_expected_left_b", 32'(exp_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
